xor_accum: RTL and testbench

XOR_ACCUM -- requirements
Module: xor_accum

---
 rtl/xor_accum.sv | 137 +++++++++++++
 tb/tb_xor_accum.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_accum.sv
// xor_accum: folds a frame of words into a running bitwise XOR and presents
// the frame result (sum, parity, saturating word count, overflow flag) on a
// valid/ready output, holding it until the consumer takes it.
module xor_accum #(
  parameter  int WIDTH     = 16,
  parameter  int MAX_WORDS = 16,
  localparam int CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count,
  output logic             out_err
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WORDS);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_parity_q, out_parity_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_err_q, out_err_d;

  logic             accept;
  logic [WIDTH-1:0] acc_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic             err_nx;

  // Word counter that sticks at MAX_WORDS once the frame is full.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == CNT_MAX) begin
      return c;
    end
    return c + CNT_W'(1);
  endfunction

  function automatic logic parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  // Ready and valid decode straight from the registered state, so there is
  // never a combinational path from out_ready to in_ready.
  assign in_ready   = (state_q == ACCUM);
  assign out_valid  = (state_q == HOLD);
  assign accept     = in_valid && in_ready;

  assign out_sum    = out_sum_q;
  assign out_parity = out_parity_q;
  assign out_count  = out_count_q;
  assign out_err    = out_err_q;

  // Next-state logic: fold accepted beats, latch the result on the last beat,
  // clear everything when the held result is consumed.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    count_d      = count_q;
    err_d        = err_q;
    out_sum_d    = out_sum_q;
    out_parity_d = out_parity_q;
    out_count_d  = out_count_q;
    out_err_d    = out_err_q;

    acc_nx = acc_q ^ in_data;
    cnt_nx = sat_inc(count_q);
    // A beat arriving when the counter is already full is the overflow beat.
    err_nx = err_q | (count_q == CNT_MAX);

    case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d   = acc_nx;
          count_d = cnt_nx;
          err_d   = err_nx;
          if (in_last) begin
            state_d      = HOLD;
            out_sum_d    = acc_nx;
            out_parity_d = parity(acc_nx);
            out_count_d  = cnt_nx;
            out_err_d    = err_nx;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d      = ACCUM;
          acc_d        = '0;
          count_d      = '0;
          err_d        = 1'b0;
          out_sum_d    = '0;
          out_parity_d = 1'b0;
          out_count_d  = '0;
          out_err_d    = 1'b0;
        end
      end
    endcase
  end

  // State and result registers; reset discards any partial frame or result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ACCUM;
      acc_q        <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
      out_sum_q    <= '0;
      out_parity_q <= 1'b0;
      out_count_q  <= '0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      count_q      <= count_d;
      err_q        <= err_d;
      out_sum_q    <= out_sum_d;
      out_parity_q <= out_parity_d;
      out_count_q  <= out_count_d;
      out_err_q    <= out_err_d;
    end
  end

endmodule

// File: tb/tb_xor_accum.sv
// tb_xor_accum: drives one input stream into two xor_accum instances
// (MAX_WORDS 16 and 4) and checks both against expected frame results.
module tb_xor_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        in_ready16, ov16, par16, err16;
  logic [15:0] sum16;
  logic [4:0]  cnt16;
  logic        in_ready4, ov4, par4, err4;
  logic [15:0] sum4;
  logic [2:0]  cnt4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] sum;
    logic        par;
    int          c16;
    logic        e16;
    int          c4;
    logic        e4;
  } exp_t;

  typedef struct {
    int              n;
    logic [19:0][15:0] w;
    int              hold;
    bit              gaps;
    exp_t            e;
  } vec_t;

  vec_t vecs[7];

  xor_accum #(.WIDTH(16), .MAX_WORDS(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .in_data(in_data), .in_last(in_last), .out_valid(ov16), .out_ready(out_ready),
    .out_sum(sum16), .out_parity(par16), .out_count(cnt16), .out_err(err16)
  );

  xor_accum #(.WIDTH(16), .MAX_WORDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_last(in_last), .out_valid(ov4), .out_ready(out_ready),
    .out_sum(sum4), .out_parity(par4), .out_count(cnt4), .out_err(err4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: result of a frame computed directly from the word list.
  function automatic exp_t model(input int n, input logic [19:0][15:0] w);
    exp_t e;
    logic [15:0] s;
    s = '0;
    for (int i = 0; i < n; i++) s = s ^ w[i];
    e.sum = s;
    e.par = logic'($countones(s) % 2);
    e.c16 = (n < 16) ? n : 16;
    e.e16 = (n > 16);
    e.c4  = (n < 4) ? n : 4;
    e.e4  = (n > 4);
    return e;
  endfunction

  function automatic vec_t mkvec(input int n, input logic [7:0][15:0] w8, input int hold,
                                 input bit gaps, input logic [15:0] sum, input logic par,
                                 input int c16, input logic e16, input int c4, input logic e4);
    vec_t v;
    v.n = n;
    v.w = '0;
    for (int i = 0; i < 8; i++) v.w[i] = w8[i];
    v.hold = hold;
    v.gaps = gaps;
    v.e.sum = sum; v.e.par = par;
    v.e.c16 = c16; v.e.e16 = e16;
    v.e.c4  = c4;  v.e.e4  = e4;
    return v;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_ov16"}, 32'(ov16), 32'd0);
    chk({tag, "_ov4"}, 32'(ov4), 32'd0);
    chk({tag, "_sum16"}, 32'(sum16), 32'd0);
    chk({tag, "_sum4"}, 32'(sum4), 32'd0);
    chk({tag, "_par"}, 32'({par16, par4}), 32'd0);
    chk({tag, "_cnt16"}, 32'(cnt16), 32'd0);
    chk({tag, "_cnt4"}, 32'(cnt4), 32'd0);
    chk({tag, "_err"}, 32'({err16, err4}), 32'd0);
    chk({tag, "_rdy"}, 32'({in_ready16, in_ready4}), 32'd3);
  endtask

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, "_ov"}, 32'({ov16, ov4}), 32'd3);
    chk({tag, "_rdy"}, 32'({in_ready16, in_ready4}), 32'd0);
    chk({tag, "_sum16"}, 32'(sum16), 32'(e.sum));
    chk({tag, "_sum4"}, 32'(sum4), 32'(e.sum));
    chk({tag, "_par16"}, 32'(par16), 32'(e.par));
    chk({tag, "_par4"}, 32'(par4), 32'(e.par));
    chk({tag, "_cnt16"}, 32'(cnt16), 32'(e.c16));
    chk({tag, "_cnt4"}, 32'(cnt4), 32'(e.c4));
    chk({tag, "_err16"}, 32'(err16), 32'(e.e16));
    chk({tag, "_err4"}, 32'(err4), 32'(e.e4));
  endtask

  // Present one beat; the block must be ready and showing no result.
  task automatic beat(input logic [15:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    chk("beat_rdy", 32'({in_ready16, in_ready4}), 32'd3);
    chk("beat_ov", 32'({ov16, ov4}), 32'd0);
    step();
    in_valid = 1'b0;
    in_data  = 'x;
    in_last  = 'x;
  endtask

  task automatic run_frame(input string tag, input int n, input logic [19:0][15:0] w,
                           input bit gaps, input int hold, input exp_t e);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 3);
        repeat (g) step();
      end
      beat(w[i], i == n - 1);
    end
    check_out(tag, e);
    // Consumer stalls; extra beats offered meanwhile must be ignored.
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'($urandom);
      in_last   = 1'b1;
      step();
      check_out({tag, "_hold"}, e);
    end
    in_valid  = 1'b0;
    in_data   = 'x;
    in_last   = 'x;
    out_ready = 1'b1;
    step();
    check_idle({tag, "_done"});
  endtask

  initial begin
    exp_t e;
    logic [19:0][15:0] w;
    int n;

    vecs[0] = mkvec(3, {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF, 16'h0F0F, 16'h00FF},
                    0, 1'b0, 16'hF00F, 1'b0, 3, 1'b0, 3, 1'b0);
    vecs[1] = mkvec(1, {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0001},
                    0, 1'b0, 16'h0001, 1'b1, 1, 1'b0, 1, 1'b0);
    vecs[2] = mkvec(2, {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h5678, 16'h1234},
                    5, 1'b0, 16'h444C, 1'b1, 2, 1'b0, 2, 1'b0);
    vecs[3] = mkvec(6, {16'h0, 16'h0, 16'h1, 16'h1, 16'h1, 16'h1, 16'h1, 16'h1},
                    0, 1'b0, 16'h0000, 1'b0, 6, 1'b0, 4, 1'b1);
    vecs[4] = mkvec(4, {16'h0, 16'h0, 16'h0, 16'h0, 16'h1000, 16'h2000, 16'h4000, 16'h8000},
                    2, 1'b0, 16'hF000, 1'b0, 4, 1'b0, 4, 1'b0);
    vecs[5] = mkvec(5, {16'h0, 16'h0, 16'h0, 16'hFF, 16'hFF, 16'hFF, 16'hFF, 16'hFF},
                    1, 1'b0, 16'h00FF, 1'b0, 5, 1'b0, 4, 1'b1);
    vecs[6] = mkvec(3, {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF, 16'h0F0F, 16'h00FF},
                    0, 1'b1, 16'hF00F, 1'b0, 3, 1'b0, 3, 1'b0);

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 'x;
    in_last   = 'x;
    out_ready = 1'b1;
    #3;
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_idle("post_reset");

    for (int i = 0; i < 7; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].n, vecs[i].w, vecs[i].gaps,
                vecs[i].hold, vecs[i].e);
    end

    // Reset mid-clock in the middle of a frame, then a single-beat frame
    // presented on the first edge after release.
    beat(16'h00FF, 1'b0);
    beat(16'h0F0F, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_idle("rst_mid");
    #3;
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'hAAAA;
    in_last  = 1'b1;
    step();
    in_valid = 1'b0;
    in_data  = 'x;
    in_last  = 'x;
    e = '{sum: 16'hAAAA, par: 1'b0, c16: 1, e16: 1'b0, c4: 1, e4: 1'b0};
    check_out("rst_aaaa", e);
    step();
    check_idle("rst_aaaa_done");

    // Reset while a result is being held discards it without an edge.
    out_ready = 1'b0;
    beat(16'h1234, 1'b1);
    e = '{sum: 16'h1234, par: 1'b1, c16: 1, e16: 1'b0, c4: 1, e4: 1'b0};
    check_out("hold_pre_rst", e);
    #2 rst_n = 1'b0;
    #1 check_idle("rst_hold");
    #3 rst_n = 1'b1;
    step();
    check_idle("rst_hold_after");
    out_ready = 1'b1;

    // Randomized frames against the reference model.
    for (int f = 0; f < 24; f++) begin
      n = $urandom_range(1, 20);
      w = '0;
      for (int i = 0; i < n; i++) w[i] = 16'($urandom);
      e = model(n, w);
      run_frame($sformatf("rnd%0d", f), n, w, bit'($urandom_range(0, 1)),
                $urandom_range(0, 3), e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
